// File: rtl/regfile_param.sv
// regfile_param: parametrised multi-read-port register file with a sequential
// bulk-clear engine, a write-drop flag and a debug tap register.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned TAP_ADDR = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*WIDTH-1:0]  rd_data,
  input  logic                    clr_req,
  output logic                    busy,
  output logic                    wr_drop,
  output logic [WIDTH-1:0]        tap_data
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_drop_q, wr_drop_d;
  // Register 0 is hard zero, so only 1..DEPTH-1 hold storage.
  logic [WIDTH-1:0]  mem_q [1:DEPTH-1];
  logic [WIDTH-1:0]  mem_d [1:DEPTH-1];
  logic              wr_accept_c;
  logic              clr_step_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: start a sweep on request, finish after the last register
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_req) state_d = ST_CLEAR;
      ST_CLEAR: if (ptr_q == LAST_PTR) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and datapath enables
  always_comb begin
    busy        = 1'b0;
    wr_accept_c = 1'b0;
    clr_step_c  = 1'b0;
    case (state_q)
      ST_IDLE:  wr_accept_c = wr_en;
      ST_CLEAR: begin
        busy       = 1'b1;
        clr_step_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next values: write, sweep pointer, drop flag
  always_comb begin
    mem_d     = mem_q;
    ptr_d     = ptr_q;
    wr_drop_d = 1'b0;
    if (wr_accept_c) begin
      // Address 0 and addresses >= DEPTH never match, so they are silently ignored.
      for (int unsigned j = 1; j < DEPTH; j++) begin
        if (wr_addr == ADDR_W'(j)) mem_d[j] = wr_data;
      end
    end
    if (!busy && clr_req) ptr_d = FIRST_PTR;
    if (clr_step_c) begin
      wr_drop_d = wr_en;
      for (int unsigned j = 1; j < DEPTH; j++) begin
        if (ptr_q == ADDR_W'(j)) mem_d[j] = '0;
      end
      ptr_d = (ptr_q == LAST_PTR) ? FIRST_PTR : ptr_q + FIRST_PTR;
    end
  end

  // Datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= FIRST_PTR;
      wr_drop_q <= 1'b0;
      for (int unsigned j = 1; j < DEPTH; j++) mem_q[j] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
      mem_q     <= mem_d;
    end
  end

  assign wr_drop = wr_drop_q;

  // Independent combinational read ports (optionally write-first)
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      for (int unsigned j = 1; j < DEPTH; j++) begin
        if (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(j)) rd_data[i*WIDTH +: WIDTH] = mem_q[j];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_accept_c && (rd_addr[i*ADDR_W +: ADDR_W] == wr_addr) && (wr_addr != '0)
          && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH))) begin
        rd_data[i*WIDTH +: WIDTH] = wr_data;
      end
`endif
    end
  end

  // Debug tap: raw register contents, never bypassed
  generate
    if (TAP_ADDR >= 1 && TAP_ADDR < DEPTH) begin : g_tap
      assign tap_data = mem_q[TAP_ADDR];
    end else begin : g_tap_zero
      assign tap_data = '0;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param: two instances (DEPTH=32 and DEPTH=24) share
// stimulus and are compared each cycle against a behavioural model.
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic        clr_req;
  logic [63:0] rd_data_a, rd_data_b;
  logic        busy_a, busy_b, wr_drop_a, wr_drop_b;
  logic [31:0] tap_a, tap_b;

  int total = 0;
  int bad = 0;

  // Model state: index 0 -> DEPTH 32, index 1 -> DEPTH 24
  logic [31:0] mdl_mem [2][32];
  int          busy_left [2];
  logic        mdl_drop [2];
  int          depth_of [2] = '{32, 24};

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .clr_req(clr_req), .busy(busy_a),
    .wr_drop(wr_drop_a), .tap_data(tap_a)
  );

  regfile_param #(.DEPTH(24)) dut24 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .clr_req(clr_req), .busy(busy_b),
    .wr_drop(wr_drop_b), .tap_data(tap_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int k, input logic [4:0] a);
    if (a == 0 || int'(a) >= depth_of[k]) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && busy_left[k] == 0 && a == wr_addr) return wr_data;
`endif
    return mdl_mem[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 32; a++) mdl_mem[k][a] = 32'd0;
      busy_left[k] = 0;
      mdl_drop[k]  = 1'b0;
    end
  endtask

  // Applies one clock edge worth of behaviour using the current inputs
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (busy_left[k] > 0) begin
        mdl_drop[k] = wr_en;
        mdl_mem[k][depth_of[k] - busy_left[k]] = 32'd0;
        busy_left[k]--;
      end else begin
        mdl_drop[k] = 1'b0;
        if (wr_en && wr_addr != 0 && int'(wr_addr) < depth_of[k]) mdl_mem[k][wr_addr] = wr_data;
        if (clr_req) busy_left[k] = depth_of[k] - 1;
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [63:0] rd;
    for (int k = 0; k < 2; k++) begin
      rd = (k == 0) ? rd_data_a : rd_data_b;
      chk($sformatf("%s.busy%0d", ph, k), 32'((k == 0) ? busy_a : busy_b), 32'(busy_left[k] > 0));
      chk($sformatf("%s.drop%0d", ph, k), 32'((k == 0) ? wr_drop_a : wr_drop_b), 32'(mdl_drop[k]));
      chk($sformatf("%s.tap%0d", ph, k), (k == 0) ? tap_a : tap_b, mdl_mem[k][3]);
      chk($sformatf("%s.rd0_%0d a=%0d", ph, k, rd_addr[4:0]), rd[31:0], model_read(k, rd_addr[4:0]));
      chk($sformatf("%s.rd1_%0d a=%0d", ph, k, rd_addr[9:5]), rd[63:32], model_read(k, rd_addr[9:5]));
    end
  endtask

  // Drive one cycle of inputs, check before and after the edge
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] r0, input logic [4:0] r1, input logic cr, input string ph);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = {r1, r0}; clr_req = cr;
    #1;
    check_all({ph, ".pre"});
    model_step();
    @(posedge clk);
    #1;
    check_all({ph, ".post"});
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; clr_req = 1'b0;
  endtask

  task automatic fill_all();
    for (int a = 1; a < 32; a++) cyc(1'b1, 5'(a), 32'(a), 5'(a), 5'(a), 1'b0, "fill");
    idle_inputs();
  endtask

  initial begin
    int n;
    idle_inputs();
    rd_addr = 10'd0;
    reset = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic write with both ports on reg 2
    cyc(1'b1, 5'd2, 32'd42, 5'd2, 5'd2, 1'b0, "wr42");
    chk("wr42.port0", rd_data_a[31:0], 32'd42);
    chk("wr42.port1", rd_data_a[63:32], 32'd42);
    chk("wr42.tap", tap_a, 32'd0);

    // Reg 0 and out-of-range (for DEPTH=24) writes
    cyc(1'b1, 5'd0, 32'd12, 5'd0, 5'd24, 1'b0, "wr0");
    cyc(1'b1, 5'd24, 32'd7, 5'd0, 5'd24, 1'b0, "wr24");
    chk("oor.rd24", rd_data_b[63:32], 32'd0);
    chk("oor.drop", 32'(wr_drop_b), 32'd0);
    idle_inputs();

    // Tap and disabled write
    cyc(1'b1, 5'd3, 32'd45, 5'd3, 5'd2, 1'b0, "wr45");
    cyc(1'b1, 5'd2, 32'd36, 5'd3, 5'd2, 1'b0, "wr36");
    cyc(1'b0, 5'd3, 32'd99, 5'd3, 5'd2, 1'b0, "nowr");
    chk("tap45", tap_a, 32'd45);
    chk("reg3", rd_data_a[31:0], 32'd45);
    chk("reg2", rd_data_a[63:32], 32'd36);

    // Full sweep with a dropped write and a repeated clr_req
    fill_all();
    cyc(1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 1'b1, "clr");
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      cyc(n == 10, 5'd5, 32'hdead, 5'($urandom_range(31)), 5'd5, n == 5, "sweep");
    end
    chk("busy_len", 32'(n), 32'd31);
    cyc(1'b1, 5'd5, 32'h55, 5'd5, 5'd31, 1'b0, "after");
    chk("after.reg5", rd_data_a[31:0], 32'h55);
    idle_inputs();

    // Asynchronous reset in the middle of a sweep
    fill_all();
    cyc(1'b0, 5'd0, 32'd0, 5'd20, 5'd31, 1'b1, "clr2");
    for (int i = 0; i < 19; i++) cyc(1'b0, 5'd0, 32'd0, 5'd20, 5'd31, 1'b0, "part");
    chk("part.reg20", rd_data_a[31:0], 32'd20);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("arst");
    chk("arst.busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 5'd20, 32'h77, 5'd20, 5'd31, 1'b0, "postrst");
    chk("postrst.reg20", rd_data_a[31:0], 32'h77);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(1), 5'($urandom_range(31)), $urandom, 5'($urandom_range(31)),
          5'($urandom_range(31)), ($urandom_range(39) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
